// File: rtl/data_mem_ctrl.sv
// ============================================================================
// Module      : data_mem_ctrl
// Description : Load/store unit that serialises B/H/W accesses onto an 8-bit
//               SRAM port, with alignment/funct3 checking and load extension.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_mem_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        done,
    output logic        err,
    output logic        sram_en,
    output logic        sram_we,
    output logic [31:0] sram_addr,
    output logic [7:0]  sram_wdata,
    input  logic [7:0]  sram_rdata
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RWAIT  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_buf;
    logic [31:0] r_rdata;
    logic [2:0]  r_f3;
    logic        r_we;
    logic        r_err;
    logic [1:0]  r_beat;

    logic        w_req;
    logic        w_req_err;
    logic [1:0]  w_last_beat;
    logic        w_last;
    logic [1:0]  w_lane;
    logic [31:0] w_merged;
    logic [31:0] w_ext;
    logic [31:0] w_wshift;

    assign w_req = mem_read | mem_write;

    // Stores take priority, so the store rules apply whenever mem_write is set
    always_comb begin
        w_req_err = 1'b0;
        if (mem_write) begin
            w_req_err = funct3[2]
                      | ((funct3[1:0] == 2'b01) & addr[0])
                      | ((funct3[1:0] == 2'b10) & (|addr[1:0]));
        end else begin
            w_req_err = (funct3[1:0] == 2'b11)
                      | (funct3 == 3'b110)
                      | ((funct3[1:0] == 2'b01) & addr[0])
                      | ((funct3 == 3'b010) & (|addr[1:0]));
        end
    end

    always_comb begin
        case (r_f3[1:0])
            2'b00:   w_last_beat = 2'd0;
            2'b01:   w_last_beat = 2'd1;
            default: w_last_beat = 2'd3;
        endcase
    end

    assign w_last = (r_beat == w_last_beat);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        stall   = 1'b0;
        done    = 1'b0;
        sram_en = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    stall  = 1'b1;
                    w_next = w_req_err ? S_DONE : S_ACCESS;
                end
            end
            S_ACCESS: begin
                stall   = 1'b1;
                sram_en = 1'b1;
                if (w_last) begin
                    w_next = r_we ? S_DONE : S_RWAIT;
                end
            end
            S_RWAIT: begin
                stall  = 1'b1;
                w_next = S_DONE;
            end
            default: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
        endcase
    end

    assign sram_we    = sram_en & r_we;
    assign err        = done & r_err;
    assign sram_addr  = r_addr + {30'd0, r_beat};
    assign w_wshift   = r_wdata >> {r_beat, 3'b000};
    assign sram_wdata = w_wshift[7:0];
    assign rdata      = r_rdata;

    // Read data lags the strobe by one cycle, so the lane being filled trails the beat
    assign w_lane = (r_state == S_RWAIT) ? r_beat : (r_beat - 2'd1);

    always_comb begin
        w_merged = r_buf;
        w_merged[{w_lane, 3'b000} +: 8] = sram_rdata;
    end

    always_comb begin
        case (r_f3)
            3'b000:  w_ext = {{24{w_merged[7]}}, w_merged[7:0]};
            3'b001:  w_ext = {{16{w_merged[15]}}, w_merged[15:0]};
            3'b100:  w_ext = {24'd0, w_merged[7:0]};
            3'b101:  w_ext = {16'd0, w_merged[15:0]};
            default: w_ext = w_merged;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_buf   <= 32'd0;
            r_rdata <= 32'd0;
            r_f3    <= 3'd0;
            r_we    <= 1'b0;
            r_err   <= 1'b0;
            r_beat  <= 2'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_addr  <= addr;
                        r_wdata <= wdata;
                        r_f3    <= funct3;
                        r_we    <= mem_write;
                        r_err   <= w_req_err;
                        r_beat  <= 2'd0;
                        r_buf   <= 32'd0;
                        if (w_req_err) begin
                            r_rdata <= 32'd0;
                        end
                    end
                end
                S_ACCESS: begin
                    if (!r_we && (r_beat != 2'd0)) begin
                        r_buf <= w_merged;
                    end
                    if (!w_last) begin
                        r_beat <= r_beat + 2'd1;
                    end
                end
                S_RWAIT: begin
                    r_rdata <= w_ext;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_data_mem_ctrl.sv
// ============================================================================
// Module      : tb_data_mem_ctrl
// Description : Randomised self-checking bench for data_mem_ctrl with a
//               transaction-level reference model and byte-addressed memory.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_data_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        stall;
    logic        done;
    logic        err;
    logic        sram_en;
    logic        sram_we;
    logic [31:0] sram_addr;
    logic [7:0]  sram_wdata;
    logic [7:0]  sram_rdata;

    int checks = 0;
    int errors = 0;

    logic [7:0]  sram_mem [logic [31:0]];
    logic [7:0]  ref_mem  [logic [31:0]];
    logic [31:0] prev_rdata;

    data_mem_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .funct3     (funct3),
        .addr       (addr),
        .wdata      (wdata),
        .rdata      (rdata),
        .stall      (stall),
        .done       (done),
        .err        (err),
        .sram_en    (sram_en),
        .sram_we    (sram_we),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] init_byte(input logic [31:0] a);
        logic [31:0] h;
        h = a * 32'd2654435761;
        return h[31:24];
    endfunction

    // Byte-wide SRAM: reads return data one cycle later, garbage otherwise
    always @(posedge clk) begin
        if (sram_en && sram_we) begin
            sram_mem[sram_addr] = sram_wdata;
        end
        if (sram_en && !sram_we) begin
            sram_rdata <= sram_mem.exists(sram_addr) ? sram_mem[sram_addr] : init_byte(sram_addr);
        end else begin
            sram_rdata <= 8'($urandom);
        end
    end

    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
    endfunction

    function automatic int nbytes(input logic [2:0] f3);
        if (f3 == 3'd0 || f3 == 3'd4) return 1;
        if (f3 == 3'd1 || f3 == 3'd5) return 2;
        return 4;
    endfunction

    function automatic bit model_err(input logic wr, input logic [2:0] f3, input logic [31:0] a);
        if (wr)
            return (f3 >= 3'd4) || (f3 == 3'd1 && a % 2 != 0) || (f3 == 3'd2 && a % 4 != 0);
        return (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)
            || ((f3 == 3'd1 || f3 == 3'd5) && a % 2 != 0)
            || (f3 == 3'd2 && a % 4 != 0);
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
        int          v;
        logic [31:0] b0, b1, b2, b3;
        b0 = 32'(ref_rd(a));
        b1 = 32'(ref_rd(a + 32'd1));
        b2 = 32'(ref_rd(a + 32'd2));
        b3 = 32'(ref_rd(a + 32'd3));
        case (f3)
            3'd0: begin
                v = int'(b0);
                if (v >= 128) v = v - 256;
                return 32'(v);
            end
            3'd4: return b0;
            3'd1: begin
                v = int'(b0 + 32'd256 * b1);
                if (v >= 32768) v = v - 65536;
                return 32'(v);
            end
            3'd5: return b0 + 32'd256 * b1;
            default: return b0 + (b1 << 8) + (b2 << 16) + (b3 << 24);
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Called at a falling edge with the block in IDLE; returns at the falling edge after DONE
    task automatic op(input logic rd, input logic wr, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] wd,
                      output int stalls, output logic [31:0] res);
        bit          e;
        int          n;
        int          total;
        logic [31:0] exp_rd;
        logic [31:0] wsh;
        mem_read  = rd;
        mem_write = wr;
        funct3    = f3;
        addr      = a;
        wdata     = wd;
        e = model_err(wr, f3, a);
        n = nbytes(f3);
        if (e)
            exp_rd = 32'd0;
        else if (!wr)
            exp_rd = model_load(f3, a);
        else
            exp_rd = prev_rdata;
        if (wr && !e) begin
            for (int k = 0; k < n; k++) begin
                wsh = wd >> (8 * k);
                ref_mem[a + 32'(k)] = wsh[7:0];
            end
        end
        total  = e ? 1 : (wr ? n + 1 : n + 2);
        stalls = 0;
        res    = 32'd0;
        for (int c = 0; c <= total; c++) begin
            #1;
            if (c == total) begin
                chk("done", 32'(done), 32'd1);
                chk("err", 32'(err), 32'(e));
                chk("stall_done", 32'(stall), 32'd0);
                chk("en_done", 32'(sram_en), 32'd0);
                chk("rdata", rdata, exp_rd);
                res = rdata;
            end else begin
                chk("stall", 32'(stall), 32'd1);
                chk("done_early", 32'(done), 32'd0);
                if (!e && c >= 1 && c <= n) begin
                    chk("sram_en", 32'(sram_en), 32'd1);
                    chk("sram_we", 32'(sram_we), 32'(wr));
                    chk("sram_addr", sram_addr, a + 32'(c - 1));
                    if (wr) begin
                        wsh = wd >> (8 * (c - 1));
                        chk("sram_wdata", 32'(sram_wdata), 32'(wsh[7:0]));
                    end
                end else begin
                    chk("sram_en_off", 32'(sram_en), 32'd0);
                    chk("sram_we_off", 32'(sram_we), 32'd0);
                end
            end
            if (stall) stalls++;
            if (c == total) begin
                // A request seen during DONE must be ignored
                addr  = $urandom;
                wdata = $urandom;
            end
            @(negedge clk);
        end
        chk("stall_count", 32'(stalls), 32'(total));
        if (e || !wr) prev_rdata = exp_rd;
    endtask

    task automatic idle(input int n);
        mem_read  = 1'b0;
        mem_write = 1'b0;
        repeat (n) begin
            #1;
            chk("idle_stall", 32'(stall), 32'd0);
            chk("idle_en", 32'(sram_en), 32'd0);
            chk("idle_done", 32'(done), 32'd0);
            @(negedge clk);
        end
    endtask

    int          st;
    logic [31:0] res;
    logic        rr, ww;
    logic [2:0]  f3r;
    logic [31:0] ar;

    initial begin
        rst_n     = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        funct3    = 3'd0;
        addr      = 32'd0;
        wdata     = 32'd0;
        prev_rdata = 32'd0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_en", 32'(sram_en), 32'd0);
        chk("rst_we", 32'(sram_we), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // Directed cases with hand-computed results
        op(1'b0, 1'b1, 3'd2, 32'h100, 32'hDEADBEEF, st, res);
        chk("sw_stalls", 32'(st), 32'd5);
        op(1'b1, 1'b0, 3'd2, 32'h100, 32'd0, st, res);
        chk("lw_val", res, 32'hDEADBEEF);
        chk("lw_stalls", 32'(st), 32'd6);
        op(1'b0, 1'b1, 3'd0, 32'h101, 32'h00000080, st, res);
        op(1'b1, 1'b0, 3'd0, 32'h101, 32'd0, st, res);
        chk("lb_val", res, 32'hFFFFFF80);
        chk("lb_stalls", 32'(st), 32'd3);
        op(1'b1, 1'b0, 3'd4, 32'h101, 32'd0, st, res);
        chk("lbu_val", res, 32'h00000080);
        op(1'b0, 1'b1, 3'd1, 32'h102, 32'h00009234, st, res);
        op(1'b1, 1'b0, 3'd1, 32'h102, 32'd0, st, res);
        chk("lh_val", res, 32'hFFFF9234);
        op(1'b1, 1'b0, 3'd2, 32'h100, 32'd0, st, res);
        chk("lw2_val", res, 32'h923480EF);
        op(1'b1, 1'b0, 3'd2, 32'h102, 32'd0, st, res);
        chk("lw_mis_val", res, 32'd0);
        chk("lw_mis_stalls", 32'(st), 32'd1);
        op(1'b1, 1'b0, 3'd3, 32'h100, 32'd0, st, res);
        chk("f3_011_stalls", 32'(st), 32'd1);
        op(1'b1, 1'b1, 3'd2, 32'h104, 32'hCAFEF00D, st, res);
        op(1'b1, 1'b0, 3'd2, 32'h104, 32'd0, st, res);
        chk("both_hi_val", res, 32'hCAFEF00D);
        idle(1);

        for (int i = 0; i < 250; i++) begin
            ww = ($urandom_range(0, 9) < 4);
            rr = !ww || ($urandom_range(0, 1) == 1);
            if (ww) begin
                if ($urandom_range(0, 4) != 0) f3r = 3'($urandom_range(0, 2));
                else f3r = 3'($urandom_range(4, 7));
            end else begin
                f3r = 3'($urandom_range(0, 7));
            end
            if ($urandom_range(0, 9) == 0) ar = 32'hFFFFFFF0 + 32'($urandom_range(0, 15));
            else ar = 32'h200 + 32'($urandom_range(0, 15));
            op(rr, ww, f3r, ar, $urandom, st, res);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end

        // Reset during beat 2 of a store, request held through reset
        mem_read  = 1'b0;
        mem_write = 1'b1;
        funct3    = 3'd2;
        addr      = 32'h300;
        wdata     = 32'h11223344;
        repeat (3) @(negedge clk);
        #1;
        chk("pre_rst_en", 32'(sram_en), 32'd1);
        chk("pre_rst_addr", sram_addr, 32'h302);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_en", 32'(sram_en), 32'd0);
        chk("mid_rst_we", 32'(sram_we), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_rdata", rdata, 32'd0);
        ref_mem[32'h300] = 8'h44;
        ref_mem[32'h301] = 8'h33;
        prev_rdata = 32'd0;
        @(negedge clk);
        chk("rst_hold_en", 32'(sram_en), 32'd0);
        rst_n = 1'b1;
        op(1'b0, 1'b1, 3'd2, 32'h300, 32'h11223344, st, res);
        op(1'b1, 1'b0, 3'd2, 32'h300, 32'd0, st, res);
        chk("post_rst_lw", res, 32'h11223344);
        op(1'b0, 1'b1, 3'd2, 32'h304, 32'h55667788, st, res);
        op(1'b1, 1'b0, 3'd2, 32'h304, 32'd0, st, res);
        chk("post_rst_lw2", res, 32'h55667788);
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
